// File: rtl/priority_encoder_rr.sv
// Registered N-input priority encoder with a one-deep valid/ready output stage.
// Supports fixed (highest index wins) and round-robin priority selected per transaction.
module priority_encoder_rr #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         w,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [$clog2(N)-1:0] y,
  output logic                 any,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] y_q, y_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         any_q, any_d;
  logic         ov_q, ov_d;

  logic [W-1:0] fix_idx_s;
  logic [W-1:0] rr_idx_s;
  logic [W-1:0] rr_pos_s;
  logic         rr_hit_s;
  logic         hit_s;
  logic         accept_s;

  assign in_ready  = !ov_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign hit_s     = en && (|w);

  assign y         = y_q;
  assign any       = any_q;
  assign out_valid = ov_q;

  // Fixed priority: the last set bit seen while scanning upward is the highest index.
  always_comb begin
    fix_idx_s = '0;
    for (int i = 0; i < N; i++) begin
      if (w[i]) begin
        fix_idx_s = W'(i);
      end else begin
        fix_idx_s = fix_idx_s;
      end
    end
  end

  // Round-robin: scan ptr, ptr-1, ... wrapping from 0 to N-1 (not 2^W-1).
  always_comb begin
    rr_idx_s = '0;
    rr_pos_s = '0;
    rr_hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (ptr_q >= W'(k)) begin
        rr_pos_s = ptr_q - W'(k);
      end else begin
        rr_pos_s = ptr_q + W'(N - k);
      end
      if (!rr_hit_s && w[rr_pos_s]) begin
        rr_idx_s = rr_pos_s;
        rr_hit_s = 1'b1;
      end else begin
        rr_hit_s = rr_hit_s;
      end
    end
  end

  // Next-state for the output stage and the round-robin pointer.
  always_comb begin
    y_d   = y_q;
    any_d = any_q;
    ov_d  = ov_q;
    ptr_d = ptr_q;
    if (accept_s) begin
      ov_d  = 1'b1;
      any_d = hit_s;
      if (!hit_s) begin
        y_d = '0;
      end else if (mode) begin
        y_d   = rr_idx_s;
        ptr_d = (rr_idx_s == '0) ? LAST : rr_idx_s - W'(1);
      end else begin
        y_d = fix_idx_s;
      end
    end else if (out_ready) begin
      ov_d = 1'b0;
    end else begin
      ov_d = ov_q;
    end
  end

  // State registers; reset leaves the pointer at N-1 so the first RR grant matches fixed priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      any_q <= 1'b0;
      ov_q  <= 1'b0;
      ptr_q <= LAST;
    end else begin
      y_q   <= y_d;
      any_q <= any_d;
      ov_q  <= ov_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Self-checking bench for priority_encoder_rr: directed plan plus random traffic,
// with N=16 and N=5 instances checked against a behavioural model.
module tb_priority_encoder_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, a_mode, a_iv, a_ordy, a_ir, a_any, a_ov;
  logic [15:0] a_w;
  logic [3:0]  a_y;
  logic        b_en, b_mode, b_iv, b_ordy, b_ir, b_any, b_ov;
  logic [4:0]  b_w;
  logic [2:0]  b_y;

  priority_encoder_rr #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .en(a_en), .w(a_w), .mode(a_mode), .in_valid(a_iv),
    .in_ready(a_ir), .y(a_y), .any(a_any), .out_valid(a_ov), .out_ready(a_ordy)
  );

  priority_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .en(b_en), .w(b_w), .mode(b_mode), .in_valid(b_iv),
    .in_ready(b_ir), .y(b_y), .any(b_any), .out_valid(b_ov), .out_ready(b_ordy)
  );

  int total = 0;
  int bad   = 0;
  int m_y[2];
  bit m_any[2];
  bit m_ov[2];
  int m_ptr[2];
  int nsz[2] = '{16, 5};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick_fixed(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int pick_rr(input logic [15:0] v, input int p, input int n);
    for (int k = 0; k < n; k++) if (v[(p - k + n) % n]) return (p - k + n) % n;
    return 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_y[s] = 0; m_any[s] = 0; m_ov[s] = 0; m_ptr[s] = nsz[s] - 1;
    end
  endtask

  task automatic model_step(input int s, input bit iv, input bit en, input bit md,
                            input logic [15:0] v, input bit ordy);
    bit acc;
    int g;
    acc = iv && (!m_ov[s] || ordy);
    if (acc) begin
      m_ov[s] = 1;
      if (!en || v == 16'h0000) begin
        m_y[s] = 0; m_any[s] = 0;
      end else if (!md) begin
        m_y[s] = pick_fixed(v, nsz[s]); m_any[s] = 1;
      end else begin
        g = pick_rr(v, m_ptr[s], nsz[s]);
        m_y[s] = g; m_any[s] = 1;
        m_ptr[s] = (g + nsz[s] - 1) % nsz[s];
      end
    end else if (m_ov[s] && ordy) begin
      m_ov[s] = 0;
    end
  endtask

  // One cycle: drive the selected instance, idle the other, check both against the model.
  task automatic step(input int s, input bit iv, input bit en, input bit md,
                      input logic [15:0] v, input bit ordy);
    if (s == 0) begin
      a_iv = iv; a_en = en; a_mode = md; a_w = v; a_ordy = ordy;
      b_iv = 1'b0; b_ordy = 1'b1;
    end else begin
      b_iv = iv; b_en = en; b_mode = md; b_w = v[4:0]; b_ordy = ordy;
      a_iv = 1'b0; a_ordy = 1'b1;
    end
    #1;
    check("a_in_ready", a_ir, (!m_ov[0] || a_ordy));
    check("b_in_ready", b_ir, (!m_ov[1] || b_ordy));
    model_step(0, a_iv, a_en, a_mode, a_w, a_ordy);
    model_step(1, b_iv, b_en, b_mode, {11'b0, b_w}, b_ordy);
    @(posedge clk);
    #1;
    check("a_y", a_y, m_y[0]);
    check("a_any", a_any, m_any[0]);
    check("a_out_valid", a_ov, m_ov[0]);
    check("b_y", b_y, m_y[1]);
    check("b_any", b_any, m_any[1]);
    check("b_out_valid", b_ov, m_ov[1]);
  endtask

  logic [15:0] fp_w[6]   = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0001, 16'h0000};
  int          fp_y[6]   = '{15, 11, 7, 3, 0, 0};
  int          fp_any[6] = '{1, 1, 1, 1, 1, 0};
  int          rr_y[4]   = '{15, 14, 13, 12};
  int          n5_y[6]   = '{4, 3, 2, 1, 0, 4};

  initial begin
    rst = 1'b1;
    a_iv = 1'b0; a_en = 1'b0; a_mode = 1'b0; a_w = '0; a_ordy = 1'b1;
    b_iv = 1'b0; b_en = 1'b0; b_mode = 1'b0; b_w = '0; b_ordy = 1'b1;
    model_reset();
    #1;
    check("rst_out_valid", a_ov, 0);
    check("rst_in_ready", a_ir, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fixed priority, back to back
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 0, fp_w[i], 1);
      check("fp_y", a_y, fp_y[i]);
      check("fp_any", a_any, fp_any[i]);
    end

    // Enable off does not move the pointer
    step(0, 1, 0, 1, 16'hF0F0, 1);
    check("en0_y", a_y, 0); check("en0_any", a_any, 0); check("en0_ov", a_ov, 1);
    step(0, 1, 0, 1, 16'h0F0F, 1);
    check("en0_y2", a_y, 0); check("en0_ov2", a_ov, 1);
    step(0, 1, 1, 1, 16'hFFFF, 1);
    check("en0_ptr_y", a_y, 15);

    // Asynchronous reset with a result pending
    step(0, 1, 1, 0, 16'h0100, 0);
    check("pend_ov", a_ov, 1);
    rst = 1'b1;
    #1;
    check("arst_y", a_y, 0); check("arst_any", a_any, 0);
    check("arst_ov", a_ov, 0); check("arst_ir", a_ir, 1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_ov", a_ov, 0);

    // Round robin from reset
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 1, 16'hFFFF, 1);
      check("rr_y", a_y, rr_y[i]);
    end
    step(0, 1, 1, 1, 16'h8001, 1);
    check("rr_8001_a", a_y, 0);
    step(0, 1, 1, 1, 16'h8001, 1);
    check("rr_8001_b", a_y, 15);

    // Backpressure and no-bubble handoff
    step(0, 1, 1, 0, 16'h0010, 1);
    check("bp_y", a_y, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 16'h8000, 0);
      check("bp_hold_y", a_y, 4);
      check("bp_hold_ir", a_ir, 0);
    end
    step(0, 1, 1, 0, 16'h8000, 1);
    check("bp_new_y", a_y, 15);
    check("bp_new_ov", a_ov, 1);

    // Non-power-of-2 wrap
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1, 1, 16'h001F, 1);
      check("n5_y", b_y, n5_y[i]);
    end

    // Random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      step(i % 2, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom), 16'($urandom) & 16'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priority_encoder_rr.md
# priority_encoder_rr

Parametrised, registered priority encoder with a valid/ready handshake on both sides. It generalises the team's 16-to-4 combinational encoder to any width N ≥ 2. It adds a round-robin mode that rotates priority after each grant. It sits between request sources and a downstream consumer that needs a registered index plus an "any request" flag.

## Interface
- N, default 16: number of request lines, N ≥ 2.
- W, localparam = $clog2(N): index width, not overridable.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  encoder enable; sampled with w on accept.
- w  input  N  request vector; bit i is request i.
- mode  input  1  0 = fixed priority, highest index wins; 1 = round-robin. Sampled on accept.
- in_valid  input  1  w/en/mode are valid this cycle.
- in_ready  output  1  block can accept this cycle.
- y  output  W  registered encoded index.
- any  output  1  registered flag, 1 if the accepted transaction had en=1 and w≠0.
- out_valid  output  1  y/any hold a result.
- out_ready  input  1  consumer takes the result this cycle.

## Operation
- One-deep output register. in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready. On accept, y, any and out_valid are loaded on the same edge.
- en=0: y=0, any=0, out_valid=1. The pointer does not move.
- en=1, w=0: y=0, any=0, out_valid=1. The pointer does not move.
- mode=0: y = highest set index of w; any=1. The pointer does not move.
- mode=1: search starts at ptr and proceeds ptr, ptr-1, …, 0, N-1, …, ptr+1. y = first set index g; any=1.
  - On that accept, ptr ← g-1 mod N, so g drops to lowest priority.
- ptr is W bits, range 0..N-1, and is reset to N-1. The first round-robin grant therefore matches fixed priority.
  - For non-power-of-2 N, the decrement from 0 wraps to N-1, never to 2^W-1.
- The pointer advances only on an accept with en=1, mode=1, any=1.
- Switching mode between transactions is legal. ptr holds its value through mode=0 traffic.
- Output transfer = out_valid && out_ready. If there is no simultaneous accept, out_valid ← 0; y and any keep their last value.
- Simultaneous transfer and accept: the new result loads and out_valid stays 1. No bubble.

## Timing
- Reset values while rst=1, taking effect immediately (asynchronous): y=0, any=0, out_valid=0, ptr=N-1. in_ready therefore reads 1.
- Latency: 1 cycle, accept edge to out_valid=1.
- Throughput: 1 result per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - y and any stay stable and in_ready=0.
  - in_valid is ignored.
  - ptr does not change.
- Reset mid-operation: any pending result is discarded. No transfer is reported after rst deasserts. The first accept may occur on the first rising edge with rst=0.
- Inputs are sampled only on accept. w, en and mode may change freely at all other times.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 → y=0, any=0, out_valid=0 and in_ready=1 immediately, without waiting for a clock edge. Then N=16, mode=1, en=1, w=0xFFFF → y=15, confirming ptr reset to 15.
- Fixed priority, N=16, mode=0, en=1, out_ready=1, back-to-back accepts of w=0xFFFF, 0x0FFF, 0x00FF, 0x000F, 0x0001, 0x0000:
  - y=15, 11, 7, 3, 0, 0 on consecutive cycles.
  - any=1, 1, 1, 1, 1, 0.
- Enable off: en=0, w=0xF0F0 then en=0, w=0x0F0F → y=0, any=0, out_valid=1 each. A following mode=1, w=0xFFFF accept gives y=15, proving ptr did not move.
- Round-robin, N=16, mode=1, from reset:
  - w=0xFFFF ×4 → y=15, 14, 13, 12.
  - Then w=0x8001 → y=0 (ptr was 11).
  - Then w=0x8001 → y=15 (ptr wrapped to 15).
- Backpressure: accept w=0x0010, mode=0, then hold out_ready=0 for 3 cycles while presenting w=0x8000 with in_valid=1:
  - y=4 stays stable and in_ready=0 throughout.
  - Raise out_ready → the y=4 transfer completes and w=0x8000 is accepted on the same edge.
  - Next cycle: y=15, out_valid=1 with no bubble.
- Non-power-of-2, N=5 (W=3), mode=1, w=5'b11111 ×6 → y=4, 3, 2, 1, 0, 4. y never reaches 5–7.
